// File: rtl/virq_arbiter.sv
// Fixed-priority arbiter that shares the CPU vectored-interrupt acknowledge path
// between NREQ peripheral requesters; index 0 has the highest priority.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no offer outstanding; arbitrate unmasked requests
// GRANT | cpu_virq raised for requester win; waiting for the CPU strobe
// ACK   | vector returned; cpu_iack_ack and virq_ack[win] held while strobe is high
module virq_arbiter #(
  parameter int NREQ  = 4,
  parameter int VEC_W = 8
) (
  input  logic                  wb_clk,
  input  logic                  sys_init_n,
  input  logic [NREQ-1:0]       virq_req,
  input  logic [NREQ*VEC_W-1:0] virq_vec,
  output logic [NREQ-1:0]       virq_ack,
  input  logic                  irq_mask,
  output logic                  cpu_virq,
  input  logic                  cpu_iack_stb,
  output logic                  cpu_iack_ack,
  output logic [VEC_W-1:0]      cpu_ivec
);

  localparam int WIN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] low_idx;
  logic [VEC_W-1:0] win_vec;
  logic             win_req;
  logic             any_req;

  assign any_req = |virq_req;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (virq_req[i]) low_idx = WIN_W'(i);
    end
  end

  always_comb begin
    win_vec = '0;
    win_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == WIN_W'(i)) begin
        win_vec = virq_vec[i*VEC_W +: VEC_W];
        win_req = virq_req[i];
      end
    end
  end

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      state        <= IDLE;
      win          <= '0;
      cpu_virq     <= 1'b0;
      cpu_iack_ack <= 1'b0;
      cpu_ivec     <= '0;
      virq_ack     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!irq_mask && any_req) begin
            win      <= low_idx;
            cpu_virq <= 1'b1;
            state    <= GRANT;
          end
        end

        GRANT: begin
          // The CPU strobe commits the grant even if the request or mask moved.
          if (cpu_iack_stb) begin
            cpu_virq     <= 1'b0;
            cpu_iack_ack <= 1'b1;
            cpu_ivec     <= win_vec;
            virq_ack     <= NREQ'(1) << win;
            state        <= ACK;
          end else if (!win_req || irq_mask) begin
            cpu_virq <= 1'b0;
            state    <= IDLE;
          end
        end

        ACK: begin
          if (!cpu_iack_stb) begin
            cpu_iack_ack <= 1'b0;
            cpu_ivec     <= '0;
            virq_ack     <= '0;
            state        <= IDLE;
          end
        end

        default: begin
          cpu_virq     <= 1'b0;
          cpu_iack_ack <= 1'b0;
          cpu_ivec     <= '0;
          virq_ack     <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_virq_arbiter.sv
// Bench for virq_arbiter: directed scenarios with literal expectations, then
// randomized requesters/CPU checked every cycle against a behavioural model.
module tb_virq_arbiter;

  localparam int NREQ  = 4;
  localparam int VEC_W = 8;

  logic                  wb_clk = 1'b0;
  logic                  sys_init_n;
  logic [NREQ-1:0]       virq_req;
  logic [NREQ*VEC_W-1:0] virq_vec;
  logic [NREQ-1:0]       virq_ack;
  logic                  irq_mask;
  logic                  cpu_virq;
  logic                  cpu_iack_stb;
  logic                  cpu_iack_ack;
  logic [VEC_W-1:0]      cpu_ivec;

  logic [VEC_W-1:0] vec_r [NREQ];

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  always #5 wb_clk = ~wb_clk;

  always_comb begin
    virq_vec = '0;
    for (int i = 0; i < NREQ; i++) virq_vec[i*VEC_W +: VEC_W] = vec_r[i];
  end

  virq_arbiter #(.NREQ(NREQ), .VEC_W(VEC_W)) dut (
    .wb_clk       (wb_clk),
    .sys_init_n   (sys_init_n),
    .virq_req     (virq_req),
    .virq_vec     (virq_vec),
    .virq_ack     (virq_ack),
    .irq_mask     (irq_mask),
    .cpu_virq     (cpu_virq),
    .cpu_iack_stb (cpu_iack_stb),
    .cpu_iack_ack (cpu_iack_ack),
    .cpu_ivec     (cpu_ivec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an offer to one requester, or a delivery to one holder.
  int               m_offer;
  int               m_holder;
  bit               m_deliver;
  logic [VEC_W-1:0] m_vec;

  function automatic int lowest(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  always @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      m_offer   = -1;
      m_holder  = 0;
      m_deliver = 1'b0;
      m_vec     = '0;
    end else if (m_deliver) begin
      if (!cpu_iack_stb) m_deliver = 1'b0;
    end else if (m_offer >= 0) begin
      if (cpu_iack_stb) begin
        m_deliver = 1'b1;
        m_holder  = m_offer;
        m_vec     = vec_r[m_offer];
        m_offer   = -1;
      end else if (!virq_req[m_offer] || irq_mask) begin
        m_offer = -1;
      end
    end else if (!irq_mask) begin
      m_offer = lowest(virq_req);
    end
  end

  always @(negedge wb_clk) begin
    if (!done) begin
      chk("model_cpu_virq", 32'(cpu_virq), 32'(m_offer >= 0));
      chk("model_iack_ack", 32'(cpu_iack_ack), 32'(m_deliver));
      chk("model_ivec", 32'(cpu_ivec), m_deliver ? 32'(m_vec) : 32'd0);
      chk("model_virq_ack", 32'(virq_ack), m_deliver ? (32'd1 << m_holder) : 32'd0);
      chk("ack_onehot", 32'($countones(virq_ack) <= 1), 32'd1);
      chk("virq_ack_excl", 32'(cpu_virq & cpu_iack_ack), 32'd0);
    end
  end

  // Advance one clock; requesters drop their request once they see their ack.
  task automatic cyc();
    @(posedge wb_clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (virq_ack[i]) virq_req[i] = 1'b0;
    @(negedge wb_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_virq"}, 32'(cpu_virq), 32'd0);
    chk({name, "_ack"},  32'(cpu_iack_ack), 32'd0);
    chk({name, "_ivec"}, 32'(cpu_ivec), 32'd0);
    chk({name, "_vack"}, 32'(virq_ack), 32'd0);
  endtask

  initial begin
    sys_init_n   = 1'b0;
    virq_req     = '0;
    irq_mask     = 1'b0;
    cpu_iack_stb = 1'b0;
    for (int i = 0; i < NREQ; i++) vec_r[i] = '0;

    cyc();
    cyc();
    chk_all_zero("reset");
    sys_init_n = 1'b1;
    cyc();

    // 1: single request
    vec_r[1] = 8'o060; virq_req[1] = 1'b1;
    cyc();
    chk("t1_virq", 32'(cpu_virq), 32'd1);
    cpu_iack_stb = 1'b1;
    cyc();
    chk("t1_ack", 32'(cpu_iack_ack), 32'd1);
    chk("t1_ivec", 32'(cpu_ivec), 32'o060);
    chk("t1_vack", 32'(virq_ack), 32'b0010);
    chk("t1_req_cleared", 32'(virq_req[1]), 32'd0);
    cpu_iack_stb = 1'b0;
    cyc();
    chk_all_zero("t1_end");

    // 2: priority between 274 and 060
    vec_r[3] = 8'o274; virq_req[3] = 1'b1;
    vec_r[1] = 8'o060; virq_req[1] = 1'b1;
    cyc();
    chk("t2_virq1", 32'(cpu_virq), 32'd1);
    cpu_iack_stb = 1'b1;
    cyc();
    chk("t2_ivec1", 32'(cpu_ivec), 32'o060);
    chk("t2_vack1", 32'(virq_ack), 32'b0010);
    cpu_iack_stb = 1'b0;
    cyc();
    chk_all_zero("t2_idle");
    cyc();
    chk("t2_virq2", 32'(cpu_virq), 32'd1);
    cpu_iack_stb = 1'b1;
    cyc();
    chk("t2_ivec2", 32'(cpu_ivec), 32'o274);
    chk("t2_vack2", 32'(virq_ack), 32'b1000);
    cpu_iack_stb = 1'b0;
    cyc();
    chk_all_zero("t2_end");

    // 3: withdrawal
    vec_r[2] = 8'o070; virq_req[2] = 1'b1;
    cyc();
    chk("t3_virq", 32'(cpu_virq), 32'd1);
    virq_req[2] = 1'b0;
    cyc();
    chk("t3_drop", 32'(cpu_virq), 32'd0);
    chk("t3_vack", 32'(virq_ack), 32'd0);
    cyc();
    chk_all_zero("t3_end");

    // 4: commit race
    vec_r[0] = 8'o100; virq_req[0] = 1'b1;
    cyc();
    chk("t4_virq", 32'(cpu_virq), 32'd1);
    virq_req[0] = 1'b0; cpu_iack_stb = 1'b1;
    cyc();
    chk("t4_ack", 32'(cpu_iack_ack), 32'd1);
    chk("t4_ivec", 32'(cpu_ivec), 32'o100);
    chk("t4_vack", 32'(virq_ack), 32'b0001);
    cpu_iack_stb = 1'b0;
    cyc();
    chk_all_zero("t4_end");

    // 5: mask
    irq_mask = 1'b1; vec_r[0] = 8'o010; virq_req[0] = 1'b1;
    cyc();
    chk("t5_masked1", 32'(cpu_virq), 32'd0);
    cyc();
    chk("t5_masked2", 32'(cpu_virq), 32'd0);
    irq_mask = 1'b0;
    cyc();
    chk("t5_unmask", 32'(cpu_virq), 32'd1);
    irq_mask = 1'b1;
    cyc();
    chk("t5_remask", 32'(cpu_virq), 32'd0);
    virq_req[0] = 1'b0; irq_mask = 1'b0;
    cyc();

    // 6: reset during ACK
    vec_r[0] = 8'o004; virq_req[0] = 1'b1;
    cyc();
    cpu_iack_stb = 1'b1;
    cyc();
    chk("t6_ack", 32'(cpu_iack_ack), 32'd1);
    #2;
    sys_init_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    cpu_iack_stb = 1'b0; virq_req[0] = 1'b1; vec_r[0] = 8'o024;
    cyc();
    sys_init_n = 1'b1;
    cyc();
    chk("t6_regrant", 32'(cpu_virq), 32'd1);
    cpu_iack_stb = 1'b1;
    cyc();
    chk("t6_ivec", 32'(cpu_ivec), 32'o024);
    cpu_iack_stb = 1'b0;
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        sys_init_n   = 1'b0;
        cpu_iack_stb = 1'b0;
      end else begin
        sys_init_n = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) irq_mask = ~irq_mask;
      for (int i = 0; i < NREQ; i++) begin
        if (!virq_req[i] && !virq_ack[i] && $urandom_range(0, 5) == 0) begin
          vec_r[i]    = VEC_W'($urandom);
          virq_req[i] = 1'b1;
        end else if (virq_req[i] && $urandom_range(0, 29) == 0) begin
          virq_req[i] = 1'b0;
        end
      end
      if (cpu_virq && !cpu_iack_stb && $urandom_range(0, 2) == 0) cpu_iack_stb = 1'b1;
      else if (cpu_iack_ack && $urandom_range(0, 1) == 0) cpu_iack_stb = 1'b0;
      cyc();
    end

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
